paridade_serial_tx: RTL
=======================

// Module: paridade_serial_tx
// PURPOSE
//  Serializer directly downstream of the parity generator: accepts a WIDTH-bit word
//  plus the parity bit the generator produced, and shifts out an async serial frame
//  (start, data LSB-first, parity, stop). Valid/ready handshake on input, single wire out.
//  Each bit is held for CLKS_PER_BIT clock cycles; no internal parity computation.
// PARAMETERS
//  WIDTH         8   data bits per frame (>=1)
//  CLKS_PER_BIT  4   clock cycles each serial bit is held (>=1)
//  STOP_BITS     1   number of stop bits, 1 or 2
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  in         in   WIDTH  data word to transmit
//  par        in   1      parity bit from generator, sent verbatim
//  valid_in   in   1      in/par valid this cycle
//  ready_out  out  1      block can accept a word (1 only in IDLE)
//  tx_out     out  1      serial line, idle high
//  busy       out  1      frame in progress (START..STOP)
//  done       out  1      one-cycle pulse on final cycle of last stop bit
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, tx_out=1, ready_out=1, busy=0, done=0, counters=0.
//  Reset wins over all other inputs; mid-frame reset aborts frame, tx_out=1 next cycle.
//  FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//   IDLE:   tx_out=1; ready_out=1. On edge with valid_in&ready_out: latch in,par; go START.
//   START:  tx_out=0 for CLKS_PER_BIT cycles.
//   DATA:   tx_out=shift[0]; after CLKS_PER_BIT cycles shift right; WIDTH bits total.
//   PARITY: tx_out=latched par for CLKS_PER_BIT cycles.
//   STOP:   tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles; done=1 on last cycle; -> IDLE.
//  All outputs registered. tx_out falls on the cycle after the accepting edge.
//  Frame length = (WIDTH+2+STOP_BITS)*CLKS_PER_BIT cycles, start to end of stop.
//  Back-to-back: minimum one IDLE cycle (ready_out=1) between frames; valid_in held
//   high is accepted in that IDLE cycle -> gap of exactly 1 high cycle beyond stop.
//  valid_in while ready_out=0 is ignored; in/par changes during frame have no effect.
//  Bit counter 0..WIDTH-1, cycle counter 0..CLKS_PER_BIT-1, both wrap to 0 on state change.
//  CLKS_PER_BIT=1: every state lasts exactly one cycle per bit; no off-by-one allowed.
//  busy=1 exactly from START first cycle to STOP last cycle inclusive.
// TESTING
//  Reset: rst=1 2 cycles, X inputs -> tx_out=1, ready_out=1, busy=0, done=0.
//  in=8'h00, par=0, CLKS_PER_BIT=4 -> tx_out: 0x4, 0x32, 0x4, 1x4; done after 44 cycles.
//  in=8'b10000010, par=0 -> data bits on line 0,1,0,0,0,0,0,1 (LSB first), parity 0.
//  in=8'b11111111, par=0 then valid_in pulsed mid-frame with 8'h01 -> ignored, frame intact.
//  rst=1 during DATA bit 3 -> next cycle tx_out=1, ready_out=1; new word then sends clean.
//  valid_in held, words 8'h01/par1 then 8'h03/par0 -> 1-cycle idle gap, both frames exact.

Source files
------------

// File: rtl/paridade_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : paridade_serial_tx
// Purpose  : Frames a data word and its externally generated parity bit into
//            an async serial stream (start, data LSB-first, parity, stop).
// Revision : 1.0 - initial release
// ============================================================================
module paridade_serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             par,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             tx_out,
    output logic             busy,
    output logic             done
);

    localparam int c_STOP_LEN = STOP_BITS * CLKS_PER_BIT;
    localparam int c_CYC_W    = (c_STOP_LEN > 1) ? $clog2(c_STOP_LEN) : 1;
    localparam int c_BIT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [c_CYC_W-1:0] c_BIT_LAST  = c_CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CYC_W-1:0] c_STOP_LAST = c_CYC_W'(c_STOP_LEN - 1);
    localparam logic [c_BIT_W-1:0] c_DATA_LAST = c_BIT_W'(WIDTH - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [2:0]         r_state;
    logic [c_CYC_W-1:0] r_cyc;
    logic [c_BIT_W-1:0] r_bit;
    logic [WIDTH-1:0]   r_shift;
    logic               r_par;

    logic [2:0]         w_state_nxt;
    logic [c_CYC_W-1:0] w_cyc_nxt;
    logic [c_BIT_W-1:0] w_bit_nxt;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic               w_par_nxt;
    logic               w_bit_end;
    logic               w_tx_nxt;
    logic               w_done_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_bit_end   = (r_cyc == c_BIT_LAST);
        case (r_state)
            c_IDLE: begin
                if (valid_in && ready_out) begin
                    w_state_nxt = c_START;
                    w_shift_nxt = in;
                    w_par_nxt   = par;
                    w_cyc_nxt   = '0;
                    w_bit_nxt   = '0;
                end
            end
            c_START: begin
                if (w_bit_end) begin
                    w_state_nxt = c_DATA;
                    w_cyc_nxt   = '0;
                end else begin
                    w_cyc_nxt = r_cyc + 1'b1;
                end
            end
            c_DATA: begin
                if (w_bit_end) begin
                    w_cyc_nxt   = '0;
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == c_DATA_LAST) begin
                        w_state_nxt = c_PARITY;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_cyc_nxt = r_cyc + 1'b1;
                end
            end
            c_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = c_STOP;
                    w_cyc_nxt   = '0;
                end else begin
                    w_cyc_nxt = r_cyc + 1'b1;
                end
            end
            c_STOP: begin
                // The whole stop period is one counted span, so two stop bits need no extra state.
                if (r_cyc == c_STOP_LAST) begin
                    w_state_nxt = c_IDLE;
                    w_cyc_nxt   = '0;
                end else begin
                    w_cyc_nxt = r_cyc + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cyc_nxt   = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered values line up with it.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            c_START:  w_tx_nxt = 1'b0;
            c_DATA:   w_tx_nxt = w_shift_nxt[0];
            c_PARITY: w_tx_nxt = w_par_nxt;
            default:  w_tx_nxt = 1'b1;
        endcase
        w_done_nxt = (w_state_nxt == c_STOP) && (w_cyc_nxt == c_STOP_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cyc     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            tx_out    <= 1'b1;
            ready_out <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cyc     <= w_cyc_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_par     <= w_par_nxt;
            tx_out    <= w_tx_nxt;
            ready_out <= (w_state_nxt == c_IDLE);
            busy      <= (w_state_nxt != c_IDLE);
            done      <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire
